// File: rtl/bsg_link_pkg.sv
// Shared definitions for the BSG source-synchronous link endpoints.
// Used by both the upstream transmitter and the downstream receiver.
package bsg_link_pkg;

  localparam int LINK_BYTE_W      = 8;
  localparam int LINK_WORD_W      = 32;
  localparam int BYTES_PER_WORD   = LINK_WORD_W / LINK_BYTE_W;
  localparam int CREDITS_PER_WORD = 2;
  localparam int BYTE_IDX_W       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } link_state_e;

  // Byte lane idx of a link word, lane 0 being the least significant byte.
  function automatic logic [LINK_BYTE_W-1:0] word_byte(
    input logic [LINK_WORD_W-1:0] word,
    input logic [BYTE_IDX_W-1:0]  idx
  );
    return word[{idx, 3'b000} +: LINK_BYTE_W];
  endfunction

endpackage

// File: rtl/bsg_credit_counter.sv
// Saturating credit counter: consumes a fixed amount per use, returns a fixed
// amount per token, clamps at MAX and flags any overflow stickily.
module bsg_credit_counter #(
  parameter int MAX         = 64,
  parameter int RETURN_AMT  = 8,
  parameter int CONSUME_AMT = 2,
  parameter int W           = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         consume_i,
  input  logic         return_i,
  output logic [W-1:0] count_o,
  output logic         err_o
);

  // Two guard bits so count + RETURN_AMT cannot wrap before the clamp compare.
  localparam int SUM_W = W + 2;

  logic [W-1:0]     count_q, count_d;
  logic             err_q, err_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(count_q);
    if (return_i) begin
      sum = sum + SUM_W'(RETURN_AMT);
    end
    if (consume_i) begin
      sum = sum - SUM_W'(CONSUME_AMT);
    end
    count_d = sum[W-1:0];
    err_d   = err_q;
    if (sum > SUM_W'(MAX)) begin
      count_d = W'(MAX);
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= W'(MAX);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/bsg_upstream_tx.sv
// Upstream link transmitter: serialises 32-bit core words onto the 8-bit io
// bus LSB first, gated by receiver-buffer credits returned as token pulses.
//
//   state | meaning
//   IDLE  | no word in flight, io_valid_out low next cycle unless accepting
//   SEND  | io bus carries byte byte_idx of the captured word (0..3)
module bsg_upstream_tx
  import bsg_link_pkg::*;
#(
  parameter int BUF_ENTRIES   = 64,
  parameter int TOKEN_CREDITS = 8,
  parameter int CREDIT_W      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         core_data_in,
  input  logic                core_valid_in,
  output logic                core_ready_out,
  input  logic                io_token_in,
  output logic [7:0]          io_data_out,
  output logic                io_valid_out,
  output logic [CREDIT_W-1:0] credits_out,
  output logic                credit_err_out
);

  link_state_e               state_q, state_d;
  logic [BYTE_IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [LINK_WORD_W-1:0]    shift_q, shift_d;
  logic [LINK_BYTE_W-1:0]    io_data_q, io_data_d;
  logic                      io_valid_q, io_valid_d;
  logic [CREDIT_W-1:0]       credits;
  logic                      credit_err;
  logic                      last_byte;
  logic                      accept;

  // Ready looks only at registered state, so a token never reaches an output
  // in the same cycle.
  assign last_byte      = (state_q == SEND) &&
                          (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign core_ready_out = ((state_q == IDLE) || last_byte) &&
                          (credits >= CREDIT_W'(CREDITS_PER_WORD));
  assign accept         = core_valid_in && core_ready_out;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    io_data_d  = io_data_q;
    io_valid_d = 1'b0;
    if (accept) begin
      state_d    = SEND;
      byte_idx_d = '0;
      shift_d    = core_data_in;
      io_data_d  = word_byte(core_data_in, '0);
      io_valid_d = 1'b1;
    end else if ((state_q == SEND) && !last_byte) begin
      byte_idx_d = byte_idx_q + 1'b1;
      io_data_d  = word_byte(shift_q, byte_idx_q + 1'b1);
      io_valid_d = 1'b1;
    end else begin
      state_d    = IDLE;
      byte_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      shift_q    <= '0;
      io_data_q  <= '0;
      io_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      io_data_q  <= io_data_d;
      io_valid_q <= io_valid_d;
    end
  end

  bsg_credit_counter #(
    .MAX         (BUF_ENTRIES),
    .RETURN_AMT  (TOKEN_CREDITS),
    .CONSUME_AMT (CREDITS_PER_WORD),
    .W           (CREDIT_W)
  ) u_credit_counter (
    .clk       (clk),
    .rst       (rst),
    .consume_i (accept),
    .return_i  (io_token_in),
    .count_o   (credits),
    .err_o     (credit_err)
  );

  assign io_data_out    = io_data_q;
  assign io_valid_out   = io_valid_q;
  assign credits_out    = credits;
  assign credit_err_out = credit_err;

endmodule
